// File: rtl/laser_fire_pkg.sv
// Shared types, limits and helpers for the laser fire controller.
package laser_fire_pkg;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEARCH   = 3'd1,
    LOCKING  = 3'd2,
    FIRE     = 3'd3,
    COOLDOWN = 3'd4
  } fire_state_e;

  // The shot counter saturates here instead of wrapping.
  localparam int unsigned SHOT_MAX = 255;

  // |a - b| for 10-bit pixel coordinates. The difference is formed in signed
  // 11 bits so a target near x=0 cannot wrap around into the aim window.
  function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/frame_qualifier.sv
// Frame-start detection from v_sync plus the aim-window test on the tracker result.
module frame_qualifier
  import laser_fire_pkg::*;
#(
  parameter int CENTER_X = 320,
  parameter int CENTER_Y = 240,
  parameter int TOL      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       aim_detected,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  output logic       frame_evt,
  output logic       qualify
);

  localparam logic [9:0]  CX    = 10'(CENTER_X);
  localparam logic [9:0]  CY    = 10'(CENTER_Y);
  localparam logic [10:0] TOL11 = 11'(TOL);

  logic        v_sync_d;
  logic        v_sync_q;
  logic [10:0] dx;
  logic [10:0] dy;

  // Next value of the delayed v_sync is simply the current input.
  always_comb begin
    v_sync_d = v_sync;
  end

  // Delayed v_sync; resets high so a low v_sync out of reset is not a frame edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v_sync_q <= 1'b1;
    else        v_sync_q <= v_sync_d;
  end

  // Falling edge of v_sync marks a new frame; window compare is combinational.
  always_comb begin
    dx        = abs_diff11(aim_x, CX);
    dy        = abs_diff11(aim_y, CY);
    frame_evt = v_sync_q & ~v_sync;
    qualify   = aim_detected && (dx <= TOL11) && (dy <= TOL11);
  end

endmodule

// File: rtl/laser_fire_ctrl.sv
// Laser shot sequencer: search, multi-frame lock, timed fire pulse, cooldown.
module laser_fire_ctrl
  import laser_fire_pkg::*;
#(
  parameter int CENTER_X        = 320,
  parameter int CENTER_Y        = 240,
  parameter int TOL             = 16,
  parameter int LOCK_FRAMES     = 3,
  parameter int FIRE_CYCLES     = 2500000,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       arm,
  input  logic       aim_detected,
  input  logic [9:0] aim_x,
  input  logic [9:0] aim_y,
  input  logic       target_off,
  output logic       laser_en,
  output logic       locked,
  output logic [2:0] state_o,
  output logic [7:0] shot_count
);

  // Counter widths; guarded so a parameter of 1 still yields a 1-bit counter.
  localparam int FW = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [FW-1:0] FIRE_LAST = FW'(FIRE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FRAMES - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0]    SHOT_SAT  = 8'(SHOT_MAX);

  logic frame_evt;
  logic qualify;

  fire_state_e   state_d,      state_q;
  logic [LW-1:0] lock_cnt_d,   lock_cnt_q;
  logic [FW-1:0] fire_cnt_d,   fire_cnt_q;
  logic [CW-1:0] cd_cnt_d,     cd_cnt_q;
  logic [7:0]    shot_count_d, shot_count_q;
  logic          laser_en_d,   laser_en_q;
  logic          locked_d,     locked_q;

  frame_qualifier #(
    .CENTER_X (CENTER_X),
    .CENTER_Y (CENTER_Y),
    .TOL      (TOL)
  ) u_frame_qualifier (
    .clk          (clk),
    .reset        (reset),
    .v_sync       (v_sync),
    .aim_detected (aim_detected),
    .aim_x        (aim_x),
    .aim_y        (aim_y),
    .frame_evt    (frame_evt),
    .qualify      (qualify)
  );

  // Next-state and counter logic; arm=0 overrides target_off, which overrides normal flow.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    fire_cnt_d   = fire_cnt_q;
    cd_cnt_d     = cd_cnt_q;
    shot_count_d = shot_count_q;

    if (!arm) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
      fire_cnt_d = '0;
      cd_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SEARCH;
        end

        SEARCH: begin
          // target_off holds us here: no lock may start while it is set.
          if (!target_off && frame_evt && qualify) begin
            if (LOCK_FRAMES == 1) begin
              state_d = FIRE;
            end else begin
              state_d    = LOCKING;
              lock_cnt_d = LW'(1);
            end
          end
        end

        LOCKING: begin
          if (target_off) begin
            state_d    = SEARCH;
            lock_cnt_d = '0;
          end else if (frame_evt) begin
            if (!qualify) begin
              state_d    = SEARCH;
              lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_LAST) begin
              state_d    = FIRE;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end
        end

        FIRE: begin
          // Frame events are ignored here, so one landing on the terminal
          // cycle never counts toward cooldown.
          if (target_off || (fire_cnt_q == FIRE_LAST)) begin
            state_d    = COOLDOWN;
            fire_cnt_d = '0;
            cd_cnt_d   = '0;
          end else begin
            fire_cnt_d = fire_cnt_q + 1'b1;
          end
        end

        COOLDOWN: begin
          if (frame_evt) begin
            if (cd_cnt_q == CD_LAST) begin
              state_d  = SEARCH;
              cd_cnt_d = '0;
            end else begin
              cd_cnt_d = cd_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          fire_cnt_d = '0;
          cd_cnt_d   = '0;
        end
      endcase

      // A shot is counted on entry to FIRE, whether or not it is cut short later.
      if ((state_d == FIRE) && (state_q != FIRE)) begin
        fire_cnt_d = '0;
        if (shot_count_q != SHOT_SAT) shot_count_d = shot_count_q + 1'b1;
      end
    end

    // Outputs derive from the next state so laser_en can only be high in FIRE.
    laser_en_d = (state_d == FIRE);
    locked_d   = (state_d == FIRE) ||
                 ((state_d == LOCKING) && (lock_cnt_d >= LOCK_LAST));
  end

  // State, counters and registered outputs; reset drops laser_en without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
      fire_cnt_q   <= '0;
      cd_cnt_q     <= '0;
      shot_count_q <= '0;
      laser_en_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      fire_cnt_q   <= fire_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      shot_count_q <= shot_count_d;
      laser_en_q   <= laser_en_d;
      locked_q     <= locked_d;
    end
  end

  assign laser_en   = laser_en_q;
  assign locked     = locked_q;
  assign state_o    = state_q;
  assign shot_count = shot_count_q;

endmodule

// File: tb/tb_laser_fire_ctrl.sv
// Directed bench for laser_fire_ctrl: lock, fire, cooldown, aborts and saturation.
`timescale 1ns/1ps
module tb_laser_fire_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       v_sync, v_sync1;
  logic       arm, arm1;
  logic       aim_detected;
  logic [9:0] aim_x, aim_y;
  logic       target_off, target_off1;
  logic       laser_en, laser_en1;
  logic       locked, locked1;
  logic [2:0] state_o, state_o1;
  logic [7:0] shot_count, shot_count1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  laser_fire_ctrl #(
    .CENTER_X(320), .CENTER_Y(240), .TOL(16),
    .LOCK_FRAMES(3), .FIRE_CYCLES(8), .COOLDOWN_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .arm(arm),
    .aim_detected(aim_detected), .aim_x(aim_x), .aim_y(aim_y),
    .target_off(target_off), .laser_en(laser_en), .locked(locked),
    .state_o(state_o), .shot_count(shot_count)
  );

  laser_fire_ctrl #(
    .CENTER_X(320), .CENTER_Y(240), .TOL(16),
    .LOCK_FRAMES(1), .FIRE_CYCLES(8), .COOLDOWN_FRAMES(2)
  ) dut1 (
    .clk(clk), .reset(reset), .v_sync(v_sync1), .arm(arm1),
    .aim_detected(aim_detected), .aim_x(aim_x), .aim_y(aim_y),
    .target_off(target_off1), .laser_en(laser_en1), .locked(locked1),
    .state_o(state_o1), .shot_count(shot_count1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame edge on dut; returns just after the edge that consumed it.
  task automatic frame();
    step();
    v_sync = 1'b0;
    step();
    v_sync = 1'b1;
  endtask

  task automatic frame1();
    step();
    v_sync1 = 1'b0;
    step();
    v_sync1 = 1'b1;
  endtask

  task automatic set_aim(input int x, input int y, input logic det);
    aim_x        = 10'(x);
    aim_y        = 10'(y);
    aim_detected = det;
  endtask

  // laser_en must never be seen outside FIRE on either instance.
  always @(negedge clk) begin
    chk("laser_only_in_fire",  {31'd0, laser_en  && (state_o  != 3'd3)}, 32'd0);
    chk("laser_only_in_fire1", {31'd0, laser_en1 && (state_o1 != 3'd3)}, 32'd0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset = 1'b0; v_sync = 1'b1; v_sync1 = 1'b1;
    arm = 1'b0; arm1 = 1'b0; target_off = 1'b0; target_off1 = 1'b0;
    set_aim(320, 240, 1'b1);
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_laser", laser_en, 0);
    chk("rst_locked", locked, 0);
    chk("rst_shots", shot_count, 0);

    // 1: centred lock over three frames, 8-cycle pulse, 2-frame cooldown
    reset = 1'b1; arm = 1'b1;
    step();
    chk("t1_search", state_o, 1);
    frame();
    chk("t1_lock1_state", state_o, 2);
    chk("t1_lock1_locked", locked, 0);
    frame();
    chk("t1_lock2_locked", locked, 1);
    frame();
    chk("t1_fire_state", state_o, 3);
    chk("t1_fire_laser", laser_en, 1);
    chk("t1_shots", shot_count, 1);
    cnt = 0;
    while (laser_en === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    chk("t1_pulse_len", cnt, 8);
    chk("t1_cooldown", state_o, 4);
    frame();
    chk("t1_cd1", state_o, 4);
    frame();
    chk("t1_cd_done", state_o, 1);

    // 2: window edges, no wrap near x=0
    set_aim(337, 240, 1'b1); frame();
    chk("t2_x337", state_o, 1);
    set_aim(10, 240, 1'b1); frame();
    chk("t2_x10", state_o, 1);
    set_aim(320, 257, 1'b1); frame();
    chk("t2_y257", state_o, 1);
    set_aim(320, 224, 1'b1); frame();
    chk("t2_y224", state_o, 2);
    set_aim(336, 240, 1'b1); frame();
    chk("t2_x336_state", state_o, 2);
    chk("t2_x336_locked", locked, 1);

    // 3: a miss drops the lock; three fresh frames needed
    set_aim(320, 240, 1'b0); frame();
    chk("t3_miss_state", state_o, 1);
    chk("t3_miss_locked", locked, 0);
    set_aim(304, 256, 1'b1);
    frame(); frame();
    chk("t3_two_frames", state_o, 2);
    frame();
    chk("t3_fire", state_o, 3);
    chk("t3_shots", shot_count, 2);

    // 4: target_off on the third FIRE cycle
    step(); step();
    chk("t4_still_fire", laser_en, 1);
    target_off = 1'b1;
    step();
    target_off = 1'b0;
    chk("t4_off_laser", laser_en, 0);
    chk("t4_off_state", state_o, 4);
    chk("t4_off_shots", shot_count, 2);
    frame(); frame();
    chk("t4_back_search", state_o, 1);

    // 5: arm drop in LOCKING and FIRE, then async reset in FIRE
    set_aim(320, 240, 1'b1);
    frame();
    chk("t5_locking", state_o, 2);
    arm = 1'b0; step();
    chk("t5_disarm_lock_state", state_o, 0);
    chk("t5_disarm_lock_locked", locked, 0);
    arm = 1'b1; step();
    chk("t5_rearm", state_o, 1);
    frame(); frame();
    chk("t5_lock_cleared", state_o, 2);
    frame();
    chk("t5_fire", state_o, 3);
    chk("t5_shots3", shot_count, 3);
    step();
    arm = 1'b0; step();
    chk("t5_disarm_fire_state", state_o, 0);
    chk("t5_disarm_fire_laser", laser_en, 0);
    chk("t5_disarm_fire_shots", shot_count, 3);
    arm = 1'b1; step();
    frame(); frame(); frame();
    chk("t5_fire2_laser", laser_en, 1);
    chk("t5_shots4", shot_count, 4);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_laser", laser_en, 0);
    chk("t5_async_state", state_o, 0);
    chk("t5_async_shots", shot_count, 0);
    #1 reset = 1'b1;

    // 6: LOCK_FRAMES=1 instance, saturation and terminal/frame coincidence
    arm = 1'b0;
    arm1 = 1'b1;
    for (int s = 1; s <= 256; s++) begin
      frame1();
      if (s == 1 || s == 256) begin
        chk("t6_fire", state_o1, 3);
        chk("t6_fire_laser", laser_en1, 1);
      end
      repeat (7) step();
      v_sync1 = 1'b0;
      step();
      v_sync1 = 1'b1;
      if (s == 1 || s == 256) begin
        chk("t6_term_state", state_o1, 4);
        chk("t6_term_laser", laser_en1, 0);
      end
      frame1();
      if (s == 1 || s == 256) chk("t6_cd_not_counted", state_o1, 4);
      frame1();
      if (s == 1 || s == 256) chk("t6_cd_done", state_o1, 1);
      if (s == 1)   chk("t6_shots1", shot_count1, 1);
      if (s == 254) chk("t6_shots254", shot_count1, 254);
      if (s == 255) chk("t6_shots255", shot_count1, 255);
    end
    chk("t6_saturated", shot_count1, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
